// File: rtl/node_pkg.sv
// Shared types and defaults for the tree-node fan-in slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package node_pkg;

  localparam int DEF_NUM_CHILDREN = 5;
  localparam int DEF_DATA_W       = 16;

  // Width of a child index; a single child still needs one tag bit.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_SRC_W = src_w(DEF_NUM_CHILDREN);

  typedef struct packed {
    logic [DEF_SRC_W-1:0]  src;
    logic                  last;
    logic [DEF_DATA_W-1:0] data;
  } fanin_beat_t;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/node_fanin_fifo.sv
// Synchronous FIFO holding tagged fan-in beats, with full/empty/level status.
// Latency: a beat pushed in cycle n is visible at the head in cycle n+1.
// Backpressure: pushes are dropped while full (registered), pops ignored while empty.
module node_fanin_fifo
  import node_pkg::*;
#(
  parameter type beat_t = fanin_beat_t,
  parameter int  DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  beat_t                  push_dat,
  input  logic                   pop,
  output beat_t                  pop_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  beat_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero while empty so outputs are clean out of reset.
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/node_fanin_collector.sv
// Merges child result streams into one tagged stream with packet-level round-robin.
// Latency: an accepted beat reaches out_* one cycle later when the buffer is empty.
// Backpressure: in_ready drops only when the output buffer is full; out_ready never feeds in_ready.
module node_fanin_collector
  import node_pkg::*;
#(
  parameter  int NUM_CHILDREN = DEF_NUM_CHILDREN,
  parameter  int DATA_W       = DEF_DATA_W,
  parameter  int FIFO_DEPTH   = 4,
  localparam int SRC_W        = src_w(NUM_CHILDREN),
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CHILDREN-1:0]        in_valid,
  input  logic [NUM_CHILDREN-1:0]        in_last,
  input  logic [NUM_CHILDREN*DATA_W-1:0] in_data,
  output logic [NUM_CHILDREN-1:0]        in_ready,
  output logic                           out_valid,
  output logic [DATA_W-1:0]              out_data,
  output logic [SRC_W-1:0]               out_src,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic [LVL_W-1:0]               level
);

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  arb_state_e       state;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] owner;
  logic             grant_vld;
  logic [SRC_W-1:0] grant_idx;
  logic             accept;
  logic             acc_last;
  logic             fifo_full;
  logic             fifo_empty;
  beat_t            push_dat;
  beat_t            head;

  function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] x);
    return (int'(x) == NUM_CHILDREN - 1) ? '0 : x + 1'b1;
  endfunction

  // Pick the granted child: the owner while locked, else the first valid child from rr_ptr upward.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (state == ARB_LOCKED) begin
      grant_vld = in_valid[owner];
      grant_idx = owner;
    end else begin
      // Descending scan so the candidate closest to rr_ptr is written last and wins.
      for (int k = NUM_CHILDREN - 1; k >= 0; k--) begin
        if (in_valid[(int'(rr_ptr) + k) % NUM_CHILDREN]) begin
          grant_vld = 1'b1;
          grant_idx = SRC_W'((int'(rr_ptr) + k) % NUM_CHILDREN);
        end
      end
    end
  end

  // One-hot ready to the granted child, held low while full or in reset.
  always_comb begin
    in_ready = '0;
    if (grant_vld && !fifo_full && rst_n) in_ready[grant_idx] = 1'b1;
  end

  assign accept        = |(in_valid & in_ready);
  assign acc_last      = in_last[grant_idx];
  assign push_dat.src  = grant_idx;
  assign push_dat.last = acc_last;
  assign push_dat.data = in_data[int'(grant_idx)*DATA_W +: DATA_W];

  // Packet ownership: lock on a non-final beat, release and advance rr_ptr on the final beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else if (accept) begin
      if (acc_last) begin
        state  <= ARB_IDLE;
        rr_ptr <= wrap_inc(grant_idx);
      end else begin
        state <= ARB_LOCKED;
        owner <= grant_idx;
      end
    end
  end

  node_fanin_fifo #(
    .beat_t (beat_t),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (accept),
    .push_dat (push_dat),
    .pop      (out_ready),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = head.data;
  assign out_src   = head.src;
  assign out_last  = head.last;

endmodule

// File: tb/tb_node_fanin_collector.sv
module tb_node_fanin_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  in_valid;
  logic [4:0]  in_last;
  logic [79:0] in_data;
  logic [4:0]  in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [2:0]  out_src;
  logic        out_last;
  logic        out_ready;
  logic [2:0]  level;

  int n_checks = 0;
  int n_pass   = 0;

  // Output beats taken by the consumer: {src, last, data}.
  logic [19:0] q[$];

  node_fanin_collector dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_last  (out_last),
    .out_ready (out_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) q.push_back({out_src, out_last, out_data});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_child(input int i, input logic v, input logic l, input logic [15:0] d);
    in_valid[i] = v;
    in_last[i]  = l;
    in_data[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    q.delete();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 5'h1F;
    in_last   = 5'h1F;
    for (int i = 0; i < 5; i++) in_data[i*16 +: 16] = 16'h0100 + 16'(i);
    step();
    step();
    n_checks++; if (in_ready !== 5'b0) $display("FAIL reset_in_ready got %b want 00000", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (level !== 3'd0) $display("FAIL reset_level got %0d want 0", level); else n_pass++;
    n_checks++; if ({out_src, out_last, out_data} !== 20'h0) $display("FAIL reset_out_fields got %h want 00000", {out_src, out_last, out_data}); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 5'b00001) $display("FAIL reset_first_grant got %b want 00001", in_ready); else n_pass++;
    step();
    in_valid = '0;
    n_checks++; if ({out_valid, out_src, out_data, level} !== {1'b1, 3'd0, 16'h0100, 3'd1})
      $display("FAIL reset_first_beat got v=%b src=%0d data=%h lvl=%0d want v=1 src=0 data=0100 lvl=1", out_valid, out_src, out_data, level);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_src [6] = '{3'd0, 3'd2, 3'd4, 3'd0, 3'd2, 3'd4};
    do_reset();
    out_ready = 1'b1;
    set_child(0, 1'b1, 1'b1, 16'h0C00);
    set_child(2, 1'b1, 1'b1, 16'h0C02);
    set_child(4, 1'b1, 1'b1, 16'h0C04);
    for (int c = 0; c < 6; c++) step();
    @(negedge clk);
    #1;
    in_valid = '0;
    n_checks++; if (q.size() != 6) $display("FAIL rr_throughput got %0d beats want 6", q.size()); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (i >= q.size()) $display("FAIL rr_beat%0d missing want src %0d", i, exp_src[i]);
      else if (q[i] !== {exp_src[i], 1'b1, 16'h0C00 + 16'(exp_src[i])})
        $display("FAIL rr_beat%0d got %h want %h", i, q[i], {exp_src[i], 1'b1, 16'h0C00 + 16'(exp_src[i])});
      else n_pass++;
    end
    step();
    step();
  endtask

  task automatic test_packet_lock();
    logic [19:0] exp [4] = '{{3'd1, 1'b0, 16'h00A1}, {3'd1, 1'b0, 16'h00A2},
                             {3'd1, 1'b1, 16'h00A3}, {3'd3, 1'b1, 16'h0033}};
    do_reset();
    out_ready = 1'b1;
    set_child(3, 1'b1, 1'b1, 16'h0033);
    set_child(1, 1'b1, 1'b0, 16'h00A1);
    #1;
    n_checks++; if (in_ready !== 5'b00010) $display("FAIL lock_beat1_ready got %b want 00010", in_ready); else n_pass++;
    step();
    set_child(1, 1'b1, 1'b0, 16'h00A2);
    #1;
    n_checks++; if (in_ready !== 5'b00010) $display("FAIL lock_beat2_ready got %b want 00010", in_ready); else n_pass++;
    step();
    set_child(1, 1'b1, 1'b1, 16'h00A3);
    #1;
    n_checks++; if (in_ready !== 5'b00010) $display("FAIL lock_beat3_ready got %b want 00010", in_ready); else n_pass++;
    step();
    set_child(1, 1'b0, 1'b0, 16'h0000);
    #1;
    n_checks++; if (in_ready !== 5'b01000) $display("FAIL lock_release_ready got %b want 01000", in_ready); else n_pass++;
    step();
    set_child(3, 1'b0, 1'b0, 16'h0000);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= q.size()) $display("FAIL lock_beat%0d missing want %h", i, exp[i]);
      else if (q[i] !== exp[i]) $display("FAIL lock_beat%0d got %h want %h", i, q[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] d = 16'h0010;
    do_reset();
    out_ready = 1'b0;
    set_child(0, 1'b1, 1'b1, d);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_checks++; if (in_ready !== 5'b00001) $display("FAIL bp_fill%0d_ready got %b want 00001", c, in_ready); else n_pass++;
      step();
      d = d + 16'h1;
      set_child(0, 1'b1, 1'b1, d);
    end
    #1;
    n_checks++; if (level !== 3'd4) $display("FAIL bp_full_level got %0d want 4", level); else n_pass++;
    n_checks++; if (in_ready !== 5'b0) $display("FAIL bp_full_ready got %b want 00000", in_ready); else n_pass++;
    step();
    n_checks++; if ({level, in_ready} !== {3'd4, 5'b0}) $display("FAIL bp_full_hold got lvl=%0d rdy=%b want lvl=4 rdy=00000", level, in_ready); else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    n_checks++; if (level !== 3'd3) $display("FAIL bp_pop_level got %0d want 3", level); else n_pass++;
    n_checks++; if (in_ready !== 5'b00001) $display("FAIL bp_resume_ready got %b want 00001", in_ready); else n_pass++;
    n_checks++; if (out_data !== 16'h0011) $display("FAIL bp_head_after_pop got %h want 0011", out_data); else n_pass++;
    step();
    set_child(0, 1'b0, 1'b0, 16'h0000);
    n_checks++; if (level !== 3'd4) $display("FAIL bp_refill_level got %0d want 4", level); else n_pass++;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    n_checks++; if ({level, out_valid} !== {3'd0, 1'b0}) $display("FAIL bp_drain got lvl=%0d v=%b want lvl=0 v=0", level, out_valid); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (i >= q.size()) $display("FAIL bp_order%0d missing want %h", i, 16'h0010 + 16'(i));
      else if (q[i] !== {3'd0, 1'b1, 16'h0010 + 16'(i)}) $display("FAIL bp_order%0d got %h want %h", i, q[i], {3'd0, 1'b1, 16'h0010 + 16'(i)});
      else n_pass++;
    end
  endtask

  task automatic test_owner_gap();
    logic [19:0] exp [3] = '{{3'd2, 1'b0, 16'h0021}, {3'd2, 1'b1, 16'h0022}, {3'd4, 1'b1, 16'h0041}};
    do_reset();
    out_ready = 1'b1;
    set_child(4, 1'b1, 1'b1, 16'h0041);
    set_child(2, 1'b1, 1'b0, 16'h0021);
    step();
    set_child(2, 1'b0, 1'b0, 16'h0000);
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++; if (in_ready !== 5'b0) $display("FAIL gap%0d_ready got %b want 00000", c, in_ready); else n_pass++;
      step();
    end
    set_child(2, 1'b1, 1'b1, 16'h0022);
    #1;
    n_checks++; if (in_ready !== 5'b00100) $display("FAIL gap_owner_return got %b want 00100", in_ready); else n_pass++;
    step();
    set_child(2, 1'b0, 1'b0, 16'h0000);
    #1;
    n_checks++; if (in_ready !== 5'b10000) $display("FAIL gap_next_grant got %b want 10000", in_ready); else n_pass++;
    step();
    set_child(4, 1'b0, 1'b0, 16'h0000);
    step();
    step();
    n_checks++; if (q.size() != 3) $display("FAIL gap_count got %0d want 3", q.size()); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i >= q.size()) $display("FAIL gap_beat%0d missing want %h", i, exp[i]);
      else if (q[i] !== exp[i]) $display("FAIL gap_beat%0d got %h want %h", i, q[i], exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    set_child(1, 1'b1, 1'b0, 16'h00B1);
    step();
    set_child(1, 1'b1, 1'b0, 16'h00B2);
    set_child(0, 1'b1, 1'b1, 16'h0005);
    #1;
    n_checks++; if ({level, in_ready} !== {3'd1, 5'b00010}) $display("FAIL mid_pre got lvl=%0d rdy=%b want lvl=1 rdy=00010", level, in_ready); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({level, out_valid, in_ready} !== {3'd0, 1'b0, 5'b0}) $display("FAIL mid_reset_now got lvl=%0d v=%b rdy=%b want 0 0 00000", level, out_valid, in_ready); else n_pass++;
    step();
    n_checks++; if ({level, out_valid} !== {3'd0, 1'b0}) $display("FAIL mid_reset_next got lvl=%0d v=%b want 0 0", level, out_valid); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 5'b00001) $display("FAIL mid_after_grant got %b want 00001", in_ready); else n_pass++;
    step();
    in_valid = '0;
    n_checks++; if ({out_valid, out_src, out_last, out_data, level} !== {1'b1, 3'd0, 1'b1, 16'h0005, 3'd1})
      $display("FAIL mid_after_beat got v=%b src=%0d last=%b data=%h lvl=%0d want 1 0 1 0005 1", out_valid, out_src, out_last, out_data, level);
    else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_owner_gap();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/node_fanin_collector.md
# node_fanin_collector

Five-way fan-in stage that sits directly upstream of a tree node and merges the result streams produced by its five child instances into one tagged stream. Arbitration is packet-level round-robin: once a child wins, it owns the output until its last beat. Accepted beats pass through a small FIFO, so the node's consumer can stall without blocking arbitration immediately.

## Interface
- NUM_CHILDREN, 5, number of child input ports (2..8)
- DATA_W, 16, payload width per beat
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥2)
- SRC_W, $clog2(NUM_CHILDREN), width of source tag (derived, not overridable)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  NUM_CHILDREN  per-child beat valid
- in_last  in  NUM_CHILDREN  per-child end-of-packet marker
- in_data  in  NUM_CHILDREN*DATA_W  per-child payload, child i at [i*DATA_W +: DATA_W]
- in_ready  out  NUM_CHILDREN  per-child accept
- out_valid  out  1  FIFO head valid
- out_data  out  DATA_W  head payload
- out_src  out  SRC_W  child index of head beat
- out_last  out  1  head end-of-packet
- out_ready  in  1  consumer accept
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Arbiter FSM, two states:
  - IDLE: if FIFO not full and any in_valid, grant first valid child searching from rr_ptr upward (wrap at NUM_CHILDREN-1→0). Accept that beat. If its in_last=1 stay IDLE and set rr_ptr = winner+1 (mod N); else go LOCKED with owner=winner.
  - LOCKED: only owner may be granted. Accept owner beat when in_valid[owner] and FIFO not full. On accepted beat with in_last=1 → IDLE, rr_ptr = owner+1 (mod N). Other children's in_ready stay 0.
- in_ready[i] = (i is granted child) & !full. Combinational from in_valid and registered state only; never from out_ready.
- Handshake: beat transfers when valid & ready both high at clock edge. Inputs must hold valid/data until accepted.
- FIFO: push on accepted input beat {src, last, data}; pop on out_valid & out_ready. Push uses registered full only: when full, no push even if popping same cycle. Push and pop in same cycle when not full and not empty: level unchanged.
- out_valid = !empty; out_* driven from head entry.

## Timing
- Reset values: out_valid=0, out_data=0, out_src=0, out_last=0, level=0, in_ready=0 during reset, FSM=IDLE, rr_ptr=0, owner=0.
- Latency: beat accepted in cycle n appears on out_* in cycle n+1 when FIFO was empty.
- Throughput: one beat per cycle sustained when out_ready held high.
- Full: level==FIFO_DEPTH → all in_ready=0; resumes cycle after first pop.
- Empty pop: out_ready with out_valid=0 has no effect.
- Pointer wrap: read/write pointers wrap modulo FIFO_DEPTH; rr_ptr wraps modulo NUM_CHILDREN.
- Owner drops valid while LOCKED: FSM stays LOCKED, no other child granted (no timeout).
- Reset mid-packet: asserting rst_n=0 clears FIFO and FSM immediately; partially collected packet is discarded.

## Structure
- Shared package node_pkg: NUM_CHILDREN default, SRC_W function, typedef fanin_beat_t {src, last, data}, enum arb_state_e {ARB_IDLE, ARB_LOCKED}.
- One sub-module: node_fanin_fifo (parameterised synchronous FIFO of fanin_beat_t, full/empty/level outputs). Arbiter and FSM live in top.

## Test plan
- Reset: hold rst_n=0 with all in_valid=1 → in_ready=0, out_valid=0, level=0; release → child 0 granted first.
- Round-robin: children 0,2,4 each send 1-beat packets (last=1) continuously, out_ready=1 → out_src sequence 0,2,4,0,2,4.
- Packet lock: child 1 sends 3-beat packet 0xA1,0xA2,0xA3 while child 3 valid → out shows src=1 ×3 then src=3; in_ready[3]=0 throughout.
- Backpressure: out_ready=0, child 0 streams → 4 beats accepted, level=4, in_ready=0 cycle 5; pulse out_ready one cycle → level=3, next cycle one more beat accepted.
- Owner gap: child 2 sends beat last=0 then drops valid 3 cycles while child 4 valid → no child 4 beat until child 2 sends last=1.
- Mid-packet reset: reset during child 1 beat 2 of 4 → level=0, out_valid=0 next cycle; after release, child 0 (rr_ptr=0) granted first.
